// File: rtl/pa_spsram_arb_2048x32.sv
// Two-requester controller for a single-port SRAM macro with active-low
// enables, a bit-level write mask and one-cycle read latency.
// After reset the array is zero-filled, then requester 0 (core) and
// requester 1 (debug/DMA) share the macro round-robin, one access per cycle.
module pa_spsram_arb_2048x32 #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int INIT_EN    = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    init_done,
  input  logic                    r0_req,
  input  logic                    r0_we,
  input  logic [ADDR_WIDTH-1:0]   r0_addr,
  input  logic [DATA_WIDTH/8-1:0] r0_wstrb,
  input  logic [DATA_WIDTH-1:0]   r0_wdata,
  output logic                    r0_gnt,
  output logic                    r0_rvalid,
  output logic [DATA_WIDTH-1:0]   r0_rdata,
  input  logic                    r1_req,
  input  logic                    r1_we,
  input  logic [ADDR_WIDTH-1:0]   r1_addr,
  input  logic [DATA_WIDTH/8-1:0] r1_wstrb,
  input  logic [DATA_WIDTH-1:0]   r1_wdata,
  output logic                    r1_gnt,
  output logic                    r1_rvalid,
  output logic [DATA_WIDTH-1:0]   r1_rdata,
  output logic                    ram_cen,
  output logic                    ram_gwen,
  output logic [DATA_WIDTH-1:0]   ram_wen,
  output logic [ADDR_WIDTH-1:0]   ram_a,
  output logic [DATA_WIDTH-1:0]   ram_d,
  input  logic [DATA_WIDTH-1:0]   ram_q
);

  localparam int SW = DATA_WIDTH / 8;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_ARB  = 1'b1;

  logic [0:0]            state;
  logic                  rst_q;     // high for the reset state cycles (while RST and one cycle after)
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  last_gnt;  // 0 = requester 0 granted last, 1 = requester 1
  logic                  r0_vld_p1;
  logic                  r1_vld_p1;
  logic                  init_act;
  logic                  arb_act;

  // Expand active-high byte strobes into the macro's active-low bit mask.
  function automatic logic [DATA_WIDTH-1:0] strb_to_wen(input logic [SW-1:0] s);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH; i++) m[i] = ~s[i/8];
    return m;
  endfunction

  assign init_act  = !rst_q && (state == S_INIT);
  assign arb_act   = !rst_q && (state == S_ARB);
  assign init_done = arb_act;

  // Round-robin: a lone requester wins; on contention the one not granted last wins.
  assign r0_gnt = arb_act && r0_req && (!r1_req || last_gnt);
  assign r1_gnt = arb_act && r1_req && (!r0_req || !last_gnt);

  // Control state: FSM, init counter, rotation pointer and read-return flags.
  always_ff @(posedge CLK) begin
    rst_q <= RST;
    if (RST) begin
      state     <= (INIT_EN != 0) ? S_INIT : S_ARB;
      init_cnt  <= '0;
      last_gnt  <= 1'b1;
      r0_vld_p1 <= 1'b0;
      r1_vld_p1 <= 1'b0;
    end else begin
      r0_vld_p1 <= r0_gnt && !r0_we;
      r1_vld_p1 <= r1_gnt && !r1_we;
      if (r0_gnt)      last_gnt <= 1'b0;
      else if (r1_gnt) last_gnt <= 1'b1;
      if (init_act) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == '1) state <= S_ARB;
      end
    end
  end

  // SRAM drive: zero-fill in INIT, otherwise the granted requester's access.
  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = init_cnt;
    ram_d    = '0;
    if (init_act) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
    end else if (r0_gnt) begin
      ram_cen  = 1'b0;
      ram_gwen = ~r0_we;
      ram_wen  = r0_we ? strb_to_wen(r0_wstrb) : '1;
      ram_a    = r0_addr;
      ram_d    = r0_wdata;
    end else if (r1_gnt) begin
      ram_cen  = 1'b0;
      ram_gwen = ~r1_we;
      ram_wen  = r1_we ? strb_to_wen(r1_wstrb) : '1;
      ram_a    = r1_addr;
      ram_d    = r1_wdata;
    end
  end

  // Read data comes straight from the macro; only the owner's valid is raised.
  assign r0_rvalid = r0_vld_p1;
  assign r1_rvalid = r1_vld_p1;
  assign r0_rdata  = ram_q;
  assign r1_rdata  = ram_q;

endmodule

// File: tb/tb_pa_spsram_arb_2048x32.sv
// Bench for pa_spsram_arb_2048x32: SRAM macro model, behavioural reference
// model compared every cycle, directed scenarios plus randomized traffic.
module tb_pa_spsram_arb_2048x32;
  localparam int DEPTH = 2048;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        init_done;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [10:0] r0_addr = 0, r1_addr = 0;
  logic [3:0]  r0_wstrb = 0, r1_wstrb = 0;
  logic [31:0] r0_wdata = 0, r1_wdata = 0;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        ram_cen, ram_gwen;
  logic [31:0] ram_wen, ram_d, ram_q;
  logic [10:0] ram_a;

  int checks = 0;
  int failures = 0;

  pa_spsram_arb_2048x32 dut (
    .CLK(CLK), .RST(RST), .init_done(init_done),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wstrb(r0_wstrb),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wstrb(r1_wstrb),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen), .ram_a(ram_a),
    .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 CLK = ~CLK;

  // SRAM macro: masked write or registered read on the clock edge.
  logic [31:0] sram [DEPTH];
  always @(posedge CLK) begin
    if (!ram_cen) begin
      if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= sram[ram_a];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Reference model: memory contents, phase, rotation and pending reads.
  logic [31:0] ref_mem [DEPTH];
  bit          m_on = 0, m_quiet = 0, m_init = 0, m_last = 1, m_p0 = 0, m_p1 = 0;
  int          m_cnt = 0;
  logic [31:0] m_d0, m_d1;

  always @(negedge CLK) begin
    bit e0, e1;
    e0 = 0; e1 = 0;
    if (m_on) begin
      if (m_quiet) begin
        chk("rst_cen", ram_cen, 1); chk("rst_gwen", ram_gwen, 1);
        chk("rst_wen", ram_wen, 32'hFFFFFFFF);
        chk("rst_gnt", {r1_gnt, r0_gnt}, 0); chk("rst_done", init_done, 0);
      end else if (m_init) begin
        chk("init_cen", ram_cen, 0); chk("init_gwen", ram_gwen, 0);
        chk("init_wen", ram_wen, 0); chk("init_a", ram_a, m_cnt[10:0]);
        chk("init_d", ram_d, 0); chk("init_gnt", {r1_gnt, r0_gnt}, 0);
        chk("init_done", init_done, 0);
      end else begin
        e0 = r0_req && (!r1_req || m_last);
        e1 = r1_req && (!r0_req || !m_last);
        chk("gnt0", r0_gnt, e0); chk("gnt1", r1_gnt, e1); chk("done", init_done, 1);
        if (e0 || e1) begin
          chk("arb_cen", ram_cen, 0);
          chk("arb_a", ram_a, e0 ? r0_addr : r1_addr);
          chk("arb_d", ram_d, e0 ? r0_wdata : r1_wdata);
          chk("arb_gwen", ram_gwen, e0 ? !r0_we : !r1_we);
          if (e0 ? r0_we : r1_we) chk("arb_wen", ram_wen, ~bytemask(e0 ? r0_wstrb : r1_wstrb));
          else                    chk("arb_wen", ram_wen, 32'hFFFFFFFF);
        end else begin
          chk("idle_cen", ram_cen, 1); chk("idle_wen", ram_wen, 32'hFFFFFFFF);
        end
      end
      chk("rvalid0", r0_rvalid, m_p0); chk("rvalid1", r1_rvalid, m_p1);
      if (m_p0) chk("rdata0", r0_rdata, m_d0);
      if (m_p1) chk("rdata1", r1_rdata, m_d1);
    end
    // advance to the state seen after the coming edge
    m_p0 = 0; m_p1 = 0;
    if (e0) begin
      if (r0_we) ref_mem[r0_addr] = (ref_mem[r0_addr] & ~bytemask(r0_wstrb)) | (r0_wdata & bytemask(r0_wstrb));
      else begin m_p0 = 1; m_d0 = ref_mem[r0_addr]; end
      m_last = 0;
    end
    if (e1) begin
      if (r1_we) ref_mem[r1_addr] = (ref_mem[r1_addr] & ~bytemask(r1_wstrb)) | (r1_wdata & bytemask(r1_wstrb));
      else begin m_p1 = 1; m_d1 = ref_mem[r1_addr]; end
      m_last = 1;
    end
    if (m_on && !m_quiet && m_init) begin
      ref_mem[m_cnt] = 0;
      if (m_cnt == DEPTH - 1) m_init = 0;
      m_cnt++;
    end
    if (m_quiet) m_quiet = 0;
    if (RST) begin
      m_on = 1; m_quiet = 1; m_init = 1; m_cnt = 0; m_last = 1; m_p0 = 0; m_p1 = 0;
    end
  end

  task automatic rst_pulse(input int n);
    RST = 1;
    repeat (n) @(posedge CLK);
    #1 RST = 0;
  endtask

  // Count macro-enabled cycles until init_done, then realign after the edge.
  task automatic wait_init(output int n);
    n = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge CLK);
      if (init_done) break;
      if (!ram_cen) n++;
    end
    @(posedge CLK); #1;
  endtask

  task automatic acc(input int p, input bit we, input logic [10:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] q, output logic [31:0] wen_s);
    bit g;
    int n;
    g = 0; n = 0; q = 'x; wen_s = 'x;
    if (p == 0) begin r0_req = 1; r0_we = we; r0_addr = a; r0_wstrb = s; r0_wdata = d; end
    else        begin r1_req = 1; r1_we = we; r1_addr = a; r1_wstrb = s; r1_wdata = d; end
    while (!g && n < 50) begin
      @(negedge CLK);
      g = (p == 0) ? r0_gnt : r1_gnt;
      wen_s = ram_wen;
      n++;
    end
    if (!g) begin
      failures++;
      $display("FAIL acc_timeout actual=no_grant required=grant");
    end
    @(posedge CLK); #1;
    r0_req = (p == 0) ? 1'b0 : r0_req;
    r1_req = (p == 1) ? 1'b0 : r1_req;
    if (!we) begin
      @(negedge CLK);
      chk("acc_rvalid", (p == 0) ? r0_rvalid : r1_rvalid, 1);
      q = (p == 0) ? r0_rdata : r1_rdata;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    int n;
    logic [31:0] q, w;
    bit b0, b1;
    int wait0, maxw0;

    // Power-up reset and full zero-fill
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    wait_init(n);
    chk("init_len", n, 2048);
    acc(1, 0, 11'h123, 0, 0, q, w);
    chk("zero_read", q, 32'h0);

    // Byte-strobed write then readback
    acc(0, 1, 11'h005, 4'b0101, 32'hDEADBEEF, q, w);
    chk("strb_wen", w, 32'hFF00FF00);
    acc(0, 0, 11'h005, 0, 0, q, w);
    chk("strb_read", q, 32'h00AD00EF);

    // Contended continuous reads alternate
    acc(0, 1, 11'h010, 4'hF, 32'h11111111, q, w);
    acc(1, 1, 11'h020, 4'hF, 32'h22222222, q, w);
    r0_req = 1; r0_we = 0; r0_addr = 11'h010;
    r1_req = 1; r1_we = 0; r1_addr = 11'h020;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("alt_gnt", {r1_gnt, r0_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("alt_rvalid", {r1_rvalid, r0_rvalid}, (k % 2 == 1) ? 2'b01 : 2'b10);
      if (r0_rvalid) chk("alt_rdata0", r0_rdata, 32'h11111111);
      if (r1_rvalid) chk("alt_rdata1", r1_rdata, 32'h22222222);
      @(posedge CLK); #1;
    end
    r0_req = 0; r1_req = 0;

    // Back-to-back writes at the top of the array
    r1_req = 1; r1_we = 1; r1_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      r1_addr = 11'h7FC + 11'(i);
      r1_wdata = 32'hA0000000 + i;
      @(negedge CLK);
      chk("b2b_gnt1", r1_gnt, 1);
      @(posedge CLK); #1;
    end
    r1_req = 0;
    acc(0, 0, 11'h7FF, 0, 0, q, w);
    chk("top_read", q, 32'hA0000003);

    // Randomized traffic on a small address window
    wait0 = 0; maxw0 = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge CLK);
      b0 = r0_gnt; b1 = r1_gnt;
      if (r0_req && !b0) wait0++; else wait0 = 0;
      if (wait0 > maxw0) maxw0 = wait0;
      @(posedge CLK); #1;
      if (!r0_req || b0) begin
        r0_req = ($urandom_range(0, 3) != 0);
        r0_we = 1'($urandom); r0_addr = 11'($urandom_range(0, 15));
        r0_wstrb = 4'($urandom); r0_wdata = $urandom;
      end
      if (!r1_req || b1) begin
        r1_req = ($urandom_range(0, 3) != 0);
        r1_we = 1'($urandom); r1_addr = 11'($urandom_range(0, 15));
        r1_wstrb = 4'($urandom); r1_wdata = $urandom;
      end
    end
    r0_req = 0; r1_req = 0;
    chk("max_wait0", maxw0 <= 1, 1);

    // Reset in the middle of INIT restarts the fill
    rst_pulse(1);
    n = 0;
    for (int k = 0; k < 1100 && n < 1000; k++) begin
      @(negedge CLK);
      if (!ram_cen) n++;
    end
    @(posedge CLK); #1;
    rst_pulse(1);
    wait_init(n);
    chk("reinit_len", n, 2048);

    // Reset sampled together with a read grant drops the rvalid
    r0_req = 1; r0_we = 0; r0_addr = 11'h005; RST = 1;
    @(negedge CLK);
    chk("rst_gnt0", r0_gnt, 1);
    @(posedge CLK); #1;
    RST = 0; r0_req = 0;
    @(negedge CLK);
    chk("rst_rvalid", r0_rvalid, 0);
    @(posedge CLK); #1;
    wait_init(n);
    chk("reinit2_len", n, 2048);
    r0_req = 1; r0_we = 0; r0_addr = 11'h001;
    r1_req = 1; r1_we = 0; r1_addr = 11'h002;
    @(negedge CLK);
    chk("first_win", {r1_gnt, r0_gnt}, 2'b01);
    @(posedge CLK); #1;
    r0_req = 0; r1_req = 0;
    repeat (3) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
